// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the integer issue path: opcodes, funct3/funct7
// codes, dispatcher state and ALU target selection.
package rv32i_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD_SUB = 3'd0;
   localparam logic [2:0] F3_SLL     = 3'd1;
   localparam logic [2:0] F3_SLT     = 3'd2;
   localparam logic [2:0] F3_SLTU    = 3'd3;
   localparam logic [2:0] F3_XOR     = 3'd4;
   localparam logic [2:0] F3_SRL_SRA = 3'd5;
   localparam logic [2:0] F3_OR      = 3'd6;
   localparam logic [2:0] F3_AND     = 3'd7;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WB    = 2'd3
   } state_e;

   typedef enum logic {
      TGT_BASE  = 1'b0,
      TGT_EXTRA = 1'b1
   } target_e;

   function automatic logic [31:0] sext_imm12(input logic [11:0] imm);
      return {{20{imm[11]}}, imm};
   endfunction

   function automatic logic [31:0] zext_shamt(input logic [4:0] shamt);
      return {27'd0, shamt};
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I OP / OP-IMM decoder: picks the ALU, builds operand 2
// and rejects anything the two ALUs cannot execute.
module alu_decode
   import rv32i_pkg::*;
(
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [11:0] imm12_i,
   input  logic [31:0] rs2_data_i,
   output target_e     target_o,
   output logic [31:0] operand_2_o,
   output logic        illegal_o
);

   logic is_shift_s;
   assign is_shift_s = (funct3_i == F3_SLL) || (funct3_i == F3_SRL_SRA);

   // Target / operand-2 selection; shifts only ever see a 5-bit amount.
   always_comb begin
      target_o    = TGT_BASE;
      operand_2_o = rs2_data_i;
      illegal_o   = 1'b0;
      case (opcode_i)
         OPC_OP: begin
            if (is_shift_s) begin
               operand_2_o = zext_shamt(rs2_data_i[4:0]);
            end else begin
               operand_2_o = rs2_data_i;
            end
            if (funct7_i == F7_BASE) begin
               target_o = TGT_BASE;
            end else if ((funct7_i == F7_ALT) &&
                         ((funct3_i == F3_ADD_SUB) || (funct3_i == F3_SRL_SRA))) begin
               target_o = TGT_EXTRA;
            end else begin
               illegal_o = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            operand_2_o = sext_imm12(imm12_i);
            case (funct3_i)
               F3_SLL: begin
                  operand_2_o = zext_shamt(imm12_i[4:0]);
                  if (funct7_i == F7_BASE) begin
                     target_o = TGT_BASE;
                  end else begin
                     illegal_o = 1'b1;
                  end
               end
               F3_SRL_SRA: begin
                  operand_2_o = zext_shamt(imm12_i[4:0]);
                  if (funct7_i == F7_BASE) begin
                     target_o = TGT_BASE;
                  end else if (funct7_i == F7_ALT) begin
                     target_o = TGT_EXTRA;
                  end else begin
                     illegal_o = 1'b1;
                  end
               end
               default: begin
                  target_o = TGT_BASE;
               end
            endcase
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage in front of the base and extra integer ALUs: accepts one
// instruction, pulses the chosen ALU, captures its result and hands it to writeback.
module alu_dispatch
   import rv32i_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ALU_LATENCY = 1
)(
   input  logic            clock,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   output logic            base_enable,
   output logic            extra_enable,
   output logic [2:0]      alu_funct3,
   output logic [XLEN-1:0] alu_operand_1,
   output logic [XLEN-1:0] alu_operand_2,
   input  logic [XLEN-1:0] base_result,
   input  logic [XLEN-1:0] extra_result,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            illegal
);

   localparam logic [2:0] LAT_LAST = 3'(ALU_LATENCY - 1);

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] op1_q, op1_d;
   logic [XLEN-1:0] op2_q, op2_d;
   logic [4:0]      rd_q, rd_d;
   target_e         tgt_q, tgt_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic            wb_valid_q, wb_valid_d;
   logic            base_en_q, base_en_d;
   logic            extra_en_q, extra_en_d;
   logic            illegal_q, illegal_d;

   target_e         dec_target_s;
   logic [31:0]     dec_op2_s;
   logic            dec_illegal_s;
   logic            accept_s;

   alu_decode u_decode (
      .opcode_i    (in_instr[6:0]),
      .funct3_i    (in_instr[14:12]),
      .funct7_i    (in_instr[31:25]),
      .imm12_i     (in_instr[31:20]),
      .rs2_data_i  (in_rs2_data),
      .target_o    (dec_target_s),
      .operand_2_o (dec_op2_s),
      .illegal_o   (dec_illegal_s)
   );

   assign in_ready = (state_q == ST_IDLE) & reset_n;
   assign accept_s = in_valid & in_ready;

   // Next-state logic; enables and illegal are single-cycle pulses by default.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      funct3_d   = funct3_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      rd_d       = rd_q;
      tgt_d      = tgt_q;
      wb_data_d  = wb_data_q;
      wb_valid_d = wb_valid_q;
      base_en_d  = 1'b0;
      extra_en_d = 1'b0;
      illegal_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && dec_illegal_s) begin
               illegal_d = 1'b1;
            end else if (accept_s) begin
               funct3_d   = in_instr[14:12];
               op1_d      = in_rs1_data;
               op2_d      = dec_op2_s;
               rd_d       = in_instr[11:7];
               tgt_d      = dec_target_s;
               base_en_d  = (dec_target_s == TGT_BASE);
               extra_en_d = (dec_target_s == TGT_EXTRA);
               state_d    = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = 3'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // The extra ALU falls back to all-ones afterwards, so this edge is the only valid one.
            if (cnt_q == LAT_LAST) begin
               wb_data_d = (tgt_q == TGT_EXTRA) ? extra_result : base_result;
               if (rd_q != 5'd0) begin
                  wb_valid_d = 1'b1;
                  state_d    = ST_WB;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_WB: begin
            if (wb_ready) begin
               wb_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_WB;
            end
         end
         default: begin
            wb_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd0;
         funct3_q   <= 3'd0;
         op1_q      <= '0;
         op2_q      <= '0;
         rd_q       <= 5'd0;
         tgt_q      <= TGT_BASE;
         wb_data_q  <= '0;
         wb_valid_q <= 1'b0;
         base_en_q  <= 1'b0;
         extra_en_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         funct3_q   <= funct3_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         rd_q       <= rd_d;
         tgt_q      <= tgt_d;
         wb_data_q  <= wb_data_d;
         wb_valid_q <= wb_valid_d;
         base_en_q  <= base_en_d;
         extra_en_q <= extra_en_d;
         illegal_q  <= illegal_d;
      end
   end

   assign base_enable   = base_en_q;
   assign extra_enable  = extra_en_q;
   assign alu_funct3    = funct3_q;
   assign alu_operand_1 = op1_q;
   assign alu_operand_2 = op2_q;
   assign wb_valid      = wb_valid_q;
   assign wb_rd         = rd_q;
   assign wb_data       = wb_data_q;
   assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with one-cycle-latency stub ALUs; every
// expected value is a hand-computed constant.
module tb_alu_dispatch;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        base_enable;
   logic        extra_enable;
   logic [2:0]  alu_funct3;
   logic [31:0] alu_operand_1;
   logic [31:0] alu_operand_2;
   logic [31:0] base_result;
   logic [31:0] extra_result;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        illegal;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] base_calc_s;
   logic [31:0] extra_calc_s;

   always #5 clock = ~clock;

   alu_dispatch dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_rs1_data   (in_rs1_data),
      .in_rs2_data   (in_rs2_data),
      .base_enable   (base_enable),
      .extra_enable  (extra_enable),
      .alu_funct3    (alu_funct3),
      .alu_operand_1 (alu_operand_1),
      .alu_operand_2 (alu_operand_2),
      .base_result   (base_result),
      .extra_result  (extra_result),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .illegal       (illegal)
   );

   // Stub ALU datapaths.
   always_comb begin
      case (alu_funct3)
         3'd0:    base_calc_s = alu_operand_1 + alu_operand_2;
         3'd1:    base_calc_s = alu_operand_1 << alu_operand_2[4:0];
         3'd2:    base_calc_s = {31'd0, $signed(alu_operand_1) < $signed(alu_operand_2)};
         3'd3:    base_calc_s = {31'd0, alu_operand_1 < alu_operand_2};
         3'd4:    base_calc_s = alu_operand_1 ^ alu_operand_2;
         3'd5:    base_calc_s = alu_operand_1 >> alu_operand_2[4:0];
         3'd6:    base_calc_s = alu_operand_1 | alu_operand_2;
         default: base_calc_s = alu_operand_1 & alu_operand_2;
      endcase
      if (alu_funct3 == 3'd0) begin
         extra_calc_s = alu_operand_1 - alu_operand_2;
      end else begin
         extra_calc_s = 32'($signed(alu_operand_1) >>> alu_operand_2[4:0]);
      end
   end

   // One-edge ALU latency; idle outputs are poison so late captures show up.
   always @(posedge clock) begin
      base_result  <= base_enable  ? base_calc_s  : 32'hDEADBEEF;
      extra_result <= extra_enable ? extra_calc_s : 32'hFFFFFFFF;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one instruction; returns just after the accept edge.
   task automatic offer(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
      @(negedge clock);
      check("ready_before_accept", 32'(in_ready), 32'd1);
      in_valid    = 1'b1;
      in_instr    = instr;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   // Full legal instruction with writeback accepted immediately.
   task automatic run_op(input string name, input logic [31:0] instr,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic is_extra, input logic [2:0] f3,
                         input logic [31:0] op2, input logic [4:0] rd,
                         input logic [31:0] data);
      offer(instr, rs1, rs2);
      @(negedge clock);
      check({name, "_base_en"},  32'(base_enable),  32'(!is_extra));
      check({name, "_extra_en"}, 32'(extra_enable), 32'(is_extra));
      check({name, "_funct3"},   32'(alu_funct3),   32'(f3));
      check({name, "_op1"},      alu_operand_1,     rs1);
      check({name, "_op2"},      alu_operand_2,     op2);
      check({name, "_ready_issue"}, 32'(in_ready),  32'd0);
      @(negedge clock);
      check({name, "_en_wait"},  32'({base_enable, extra_enable}), 32'd0);
      check({name, "_wbv_wait"}, 32'(wb_valid),     32'd0);
      @(negedge clock);
      check({name, "_wb_valid"}, 32'(wb_valid),     32'd1);
      check({name, "_wb_rd"},    32'(wb_rd),        32'(rd));
      check({name, "_wb_data"},  wb_data,           data);
      @(negedge clock);
      check({name, "_wbv_after"}, 32'(wb_valid),    32'd0);
      check({name, "_ready_after"}, 32'(in_ready),  32'd1);
   endtask

   task automatic run_illegal(input string name, input logic [31:0] instr);
      offer(instr, 32'h11111111, 32'h22222222);
      @(negedge clock);
      check({name, "_pulse"},    32'(illegal),      32'd1);
      check({name, "_no_en"},    32'({base_enable, extra_enable}), 32'd0);
      check({name, "_ready"},    32'(in_ready),     32'd1);
      @(negedge clock);
      check({name, "_pulse_end"}, 32'(illegal),     32'd0);
      check({name, "_no_wb"},    32'(wb_valid),     32'd0);
   endtask

   initial begin
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_instr    = 32'd0;
      in_rs1_data = 32'd0;
      in_rs2_data = 32'd0;
      wb_ready    = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_ready",    32'(in_ready),     32'd0);
      check("rst_wb_valid", 32'(wb_valid),     32'd0);
      check("rst_enables",  32'({base_enable, extra_enable}), 32'd0);
      check("rst_illegal",  32'(illegal),      32'd0);
      check("rst_wb_data",  wb_data,           32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check("post_rst_ready", 32'(in_ready),   32'd1);

      run_op("sub",  32'h40208133, 32'd5, 32'd7, 1'b1, 3'd0, 32'd7, 5'd2, 32'hFFFFFFFE);
      run_op("sra",  32'h4020D2B3, 32'h80000000, 32'd36, 1'b1, 3'd5, 32'd4, 5'd5, 32'hF8000000);
      run_op("srai", 32'h4030D313, 32'h80000000, 32'd0, 1'b1, 3'd5, 32'd3, 5'd6, 32'hF0000000);
      run_op("addi", 32'hFFF00093, 32'd0, 32'd0, 1'b0, 3'd0, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFF);
      run_op("add",  32'h002081B3, 32'd10, 32'd20, 1'b0, 3'd0, 32'd20, 5'd3, 32'd30);

      run_illegal("ill_zero", 32'h00000000);
      run_illegal("ill_slli_f7", 32'h40109093);
      run_illegal("ill_xor_f7", 32'h4020C133);

      // Writeback back-pressure: add x3,x1,x2 with 1+2.
      wb_ready = 1'b0;
      offer(32'h002081B3, 32'd1, 32'd2);
      repeat (2) @(negedge clock);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_wb_valid", 32'(wb_valid), 32'd1);
         check("bp_wb_data",  wb_data,       32'd3);
         check("bp_wb_rd",    32'(wb_rd),    32'd3);
         check("bp_ready",    32'(in_ready), 32'd0);
      end
      wb_ready = 1'b1;
      @(negedge clock);
      check("bp_release_valid", 32'(wb_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      run_op("xori", 32'h0FF0C093, 32'h0000F0F0, 32'd0, 1'b0, 3'd4, 32'h000000FF, 5'd1, 32'h0000F00F);

      // Reset while waiting on the ALU.
      offer(32'h40208133, 32'd9, 32'd4);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      check("midrst_wb_valid", 32'(wb_valid),   32'd0);
      check("midrst_ready",    32'(in_ready),   32'd0);
      check("midrst_op1",      alu_operand_1,   32'd0);
      check("midrst_funct3",   32'(alu_funct3), 32'd0);
      check("midrst_illegal",  32'(illegal),    32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check("midrst_no_wb",    32'(wb_valid),   32'd0);
      check("midrst_ready_up", 32'(in_ready),   32'd1);

      // rd = x0: add x0,x1,x2 issues but never writes back.
      offer(32'h00208033, 32'd3, 32'd4);
      @(negedge clock);
      check("rd0_base_en", 32'(base_enable), 32'd1);
      @(negedge clock);
      check("rd0_wait_wbv", 32'(wb_valid), 32'd0);
      @(negedge clock);
      check("rd0_no_wb",   32'(wb_valid), 32'd0);
      check("rd0_ready",   32'(in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
